// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map, select codes and the select-update helper.
package keypad_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    REL_DEB  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_A   = 4'hA;
  localparam logic [3:0] KEY_B   = 4'hB;
  localparam logic [3:0] KEY_C   = 4'hC;
  localparam logic [3:0] KEY_D   = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;

  // Indexed by {row, col}
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [SEL_W-1:0] sel_next(
    input logic [3:0]       code,
    input logic [SEL_W-1:0] cur
  );
    case (code)
      KEY_A:   return 4'b0001;
      KEY_B:   return 4'b0010;
      KEY_C:   return 4'b0100;
      KEY_D:   return 4'b1000;
      KEY_CLR: return '0;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets both stages to RST_VAL.
module sync2 #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce,
// one-cycle key event and latched one-hot select.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic [SEL_W-1:0] sel
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYC - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       cidx_q, cidx_d;
  logic [1:0]       crow_q, crow_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [3:0] row_s;
  logic [1:0] low_row;
  logic       any_low;
  logic       row_up;
  logic [3:0] new_code;

  sync2 #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  // Lowest-index low row wins within a column
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_row = 2'(i);
    end
  end

  assign any_low  = ~&row_s;
  assign row_up   = row_s[crow_q];
  assign new_code = KEY_MAP[{crow_q, cidx_q}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      cidx_q  <= 2'd0;
      crow_q  <= 2'd0;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cidx_q  <= cidx_d;
      crow_q  <= crow_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cidx_d  = cidx_q;
    crow_d  = crow_q;
    valid_d = 1'b0;
    code_d  = code_q;
    sel_d   = sel_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_TC) begin
          cnt_d = '0;
          if (any_low) begin
            crow_d  = low_row;
            state_d = DEBOUNCE;
          end else begin
            cidx_d = cidx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_up) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else if (cnt_q == DEB_TC) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          code_d  = new_code;
          sel_d   = sel_next(new_code, sel_q);
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (row_up) begin
          cnt_d   = '0;
          state_d = REL_DEB;
        end
      end
      REL_DEB: begin
        if (!row_up) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_TC) begin
          cnt_d   = '0;
          cidx_d  = cidx_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col_n     = ~(4'b0001 << cidx_q);
    key_valid = valid_q;
    key_code  = code_q;
    sel       = sel_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple
// keypad model (one key at a time) and a pulse monitor.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] sel;

  logic       key_down;
  logic [1:0] krow, kcol;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int wide_cnt = 0;
  logic prev_valid = 1'b0;
  int base;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    if (key_down && !col_n[kcol]) row_n[krow] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) pulse_cnt++;
    if (key_valid && prev_valid) wide_cnt++;
    prev_valid = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input logic [1:0] r, input logic [1:0] c);
    krow = r;
    kcol = c;
    key_down = 1'b1;
    tick(40);
    key_down = 1'b0;
    tick(20);
  endtask

  initial begin
    logic [3:0] e;
    int n;
    rst_n = 1'b0;
    key_down = 1'b0;
    krow = 2'd0;
    kcol = 2'd0;
    tick(3);
    chk("rst_col", col_n, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_sel", sel, 4'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      e = ~(4'b0001 << (((i + 1) / 4) % 4));
      chk("idle_col", col_n, e);
    end
    chk("idle_pulses", pulse_cnt, 0);
    chk("idle_code", key_code, 4'h0);
    chk("idle_sel", sel, 4'h0);

    base = pulse_cnt;
    krow = 2'd1;
    kcol = 2'd1;
    key_down = 1'b1;
    tick(60);
    chk("press5_held_col", col_n, 4'b1101);
    key_down = 1'b0;
    tick(10);
    chk("rel5_col_hold", col_n, 4'b1101);
    tick(1);
    chk("rel5_col_next", col_n, 4'b1011);
    chk("press5_pulses", pulse_cnt - base, 1);
    chk("press5_code", key_code, 4'h5);
    chk("press5_sel", sel, 4'h0);
    tick(20);

    press_release(2'd0, 2'd3);
    chk("sel_a", sel, 4'b0001);
    chk("code_a", key_code, 4'hA);
    press_release(2'd1, 2'd3);
    chk("sel_b", sel, 4'b0010);
    chk("code_b", key_code, 4'hB);
    press_release(2'd1, 2'd3);
    chk("sel_b_again", sel, 4'b0010);
    press_release(2'd2, 2'd3);
    chk("sel_c", sel, 4'b0100);
    chk("code_c", key_code, 4'hC);
    press_release(2'd3, 2'd3);
    chk("sel_d", sel, 4'b1000);
    chk("code_d", key_code, 4'hD);
    press_release(2'd0, 2'd1);
    chk("sel_keep", sel, 4'b1000);
    chk("code_2", key_code, 4'h2);
    press_release(2'd3, 2'd0);
    chk("sel_clr", sel, 4'b0000);
    chk("code_e", key_code, 4'hE);
    chk("seq_pulses", pulse_cnt - base, 8);

    base = pulse_cnt;
    n = 0;
    while (col_n != 4'b1101 && n < 40) begin
      tick(1);
      n++;
    end
    chk("wait_col1", col_n, 4'b1101);
    krow = 2'd1;
    kcol = 2'd1;
    key_down = 1'b1;
    tick(3);
    key_down = 1'b0;
    tick(40);
    chk("bounce_pulses", pulse_cnt - base, 0);
    chk("bounce_code", key_code, 4'hE);
    press_release(2'd1, 2'd1);
    chk("after_bounce_pulses", pulse_cnt - base, 1);
    chk("after_bounce_code", key_code, 4'h5);

    base = pulse_cnt;
    krow = 2'd2;
    kcol = 2'd2;
    key_down = 1'b1;
    tick(100);
    key_down = 1'b0;
    tick(3);
    key_down = 1'b1;
    tick(2);
    key_down = 1'b0;
    tick(3);
    key_down = 1'b1;
    tick(2);
    key_down = 1'b0;
    tick(9);
    chk("relb_col_hold", col_n, 4'b1011);
    tick(1);
    chk("relb_col_next", col_n, 4'b0111);
    tick(20);
    chk("relb_pulses", pulse_cnt - base, 1);
    chk("relb_code", key_code, 4'h9);

    krow = 2'd2;
    kcol = 2'd3;
    key_down = 1'b1;
    n = 0;
    while (sel != 4'b0100 && n < 60) begin
      tick(1);
      n++;
    end
    chk("wait_sel_c", sel, 4'b0100);
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", sel, 4'b0000);
    chk("mid_rst_col", col_n, 4'b1110);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_code", key_code, 4'h0);
    tick(2);
    base = pulse_cnt;
    rst_n = 1'b1;
    tick(60);
    chk("post_rst_pulses", pulse_cnt - base, 1);
    chk("post_rst_sel", sel, 4'b0100);
    chk("post_rst_code", key_code, 4'hC);
    key_down = 1'b0;
    tick(20);
    chk("post_rel_pulses", pulse_cnt - base, 1);
    chk("pulse_width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
